// File: rtl/counter_step_arb_if.sv
// Purpose : requester/counter bundle for counter_step_arb.
//   master : client side (drives requests, sat_en and the counter value cnt)
//   slave  : arbiter side (drives req_ready, inc/dec strobes and burst status)
// Signals :
//   req_valid/req_dir [NUM_REQ]  per-requester request and direction (1 = up)
//   req_len [NUM_REQ*LEN_W]      burst length, requester i at [i*LEN_W +: LEN_W]
//   req_ready [NUM_REQ]          one-hot accept strobe
//   sat_en, cnt[8]               saturation guard enable, current counter value
//   inc, dec                     counter step strobes
//   busy, grant_id, done, sat_stop  burst status
interface counter_step_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 4
);
    localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_dir;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     sat_en;
    logic [7:0]               cnt;
    logic                     inc;
    logic                     dec;
    logic                     busy;
    logic [GID_W-1:0]         grant_id;
    logic                     done;
    logic                     sat_stop;

    modport master (
        output req_valid, req_dir, req_len, sat_en, cnt,
        input  req_ready, inc, dec, busy, grant_id, done, sat_stop
    );

    modport slave (
        input  req_valid, req_dir, req_len, sat_en, cnt,
        output req_ready, inc, dec, busy, grant_id, done, sat_stop
    );
endinterface

// File: rtl/counter_step_arb.sv
// Purpose : shares one 8-bit inc/dec counter among NUM_REQ requesters. A round-robin
//           arbiter accepts one burst request; an IDLE/RUN/DONE FSM then strobes inc or
//           dec once per cycle for LEN steps, optionally stopping early at 8'hFF / 8'h00.
// Ports   :
//   clk    in  rising-edge clock
//   rst_n  in  async active-low reset
//   bus    counter_step_arb_if.slave (requests, counter value, strobes, status)
// Notes   : req_ready, inc and dec are combinational: ready must answer valid in the same
//           cycle, and the saturation guard must see the live counter value.
module counter_step_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    counter_step_arb_if.slave     bus
);
    localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GID_W-1:0]   r_rr_ptr;
    logic [GID_W-1:0]   w_rr_ptr_nxt;
    logic [GID_W-1:0]   r_grant_id;
    logic [GID_W-1:0]   w_grant_id_nxt;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   w_remaining_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               r_sat_stop;
    logic               w_sat_stop_nxt;

    logic               w_any_req;
    logic [GID_W-1:0]   w_pick;
    logic [GID_W-1:0]   w_pick_inc;
    logic [LEN_W-1:0]   w_pick_len;
    int unsigned        w_idx;
    logic               w_sat_hit;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_inc;
    logic               w_dec;

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        w_idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = 32'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_any_req && bus.req_valid[GID_W'(w_idx)]) begin
                w_any_req = 1'b1;
                w_pick    = GID_W'(w_idx);
            end
        end
    end

    // Length of the candidate request and the pointer value that follows it.
    always_comb begin
        w_pick_len = bus.req_len[32'(w_pick)*LEN_W +: LEN_W];
        if (32'(w_pick) == NUM_REQ - 1) begin
            w_pick_inc = '0;
        end else begin
            w_pick_inc = w_pick + GID_W'(1);
        end
    end

    // Step would push the counter past its limit in the burst direction.
    assign w_sat_hit = bus.sat_en &&
                       (r_dir ? (bus.cnt == 8'hFF) : (bus.cnt == 8'h00));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_remaining <= '0;
            r_dir       <= 1'b0;
            r_sat_stop  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_remaining <= w_remaining_nxt;
            r_dir       <= w_dir_nxt;
            r_sat_stop  <= w_sat_stop_nxt;
        end
    end

    // Next-state and strobe logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_id_nxt  = r_grant_id;
        w_remaining_nxt = r_remaining;
        w_dir_nxt       = r_dir;
        w_sat_stop_nxt  = 1'b0;
        w_ready         = '0;
        w_inc           = 1'b0;
        w_dec           = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_ready[w_pick] = 1'b1;
                    w_dir_nxt       = bus.req_dir[w_pick];
                    w_remaining_nxt = w_pick_len;
                    w_grant_id_nxt  = w_pick;
                    w_rr_ptr_nxt    = w_pick_inc;
                    // Zero-length bursts skip RUN and only report done.
                    w_state_nxt     = (w_pick_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_sat_hit) begin
                    // Suppress this step; sat_stop is held through the DONE cycle.
                    w_sat_stop_nxt = 1'b1;
                    w_state_nxt    = S_DONE;
                end else begin
                    w_inc           = r_dir;
                    w_dec           = !r_dir;
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs are decodes of registered state.
    assign bus.req_ready = w_ready;
    assign bus.inc       = w_inc;
    assign bus.dec       = w_dec;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.sat_stop  = r_sat_stop;
    assign bus.grant_id  = r_grant_id;
endmodule

// File: tb/tb_counter_step_arb.sv
// Purpose : self-checking bench for counter_step_arb. Owns the shared 8-bit counter and
//           predicts each burst (grant, step count, early stop, final value, done latency)
//           arithmetically from the request set and the starting counter value.
module tb_counter_step_arb;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LEN_W   = 4;

    logic clk;
    logic rst_n;

    counter_step_arb_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus();

    counter_step_arb #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The counter being shared, with a bench-side preload.
    logic [7:0] r_cnt;
    logic       load;
    logic [7:0] load_val;
    always @(posedge clk) begin
        if (load)         r_cnt <= load_val;
        else if (bus.inc) r_cnt <= r_cnt + 8'd1;
        else if (bus.dec) r_cnt <= r_cnt - 8'd1;
    end
    assign bus.cnt = r_cnt;

    int n_cmp    = 0;
    int n_err    = 0;
    int model_rr = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One request set, arbitrated from idle; all valids are withdrawn after the accept.
    task automatic run_burst(input logic [3:0] mask, input logic [3:0] dirs,
                             input logic [15:0] lens, input logic sat, input logic [7:0] c0);
        int g = -1;
        int len, room, steps, exp_lat, exp_final;
        bit d, exp_sat, seen;
        int cyc = 0, n_inc = 0, n_dec = 0;

        for (int k = 0; k < int'(NUM_REQ); k++) begin
            int idx = (model_rr + k) % int'(NUM_REQ);
            if (g < 0 && mask[idx]) g = idx;
        end
        len  = int'(lens[g*LEN_W +: LEN_W]);
        d    = dirs[g];
        room = d ? (255 - int'(c0)) : int'(c0);
        if (sat && len > room) begin
            steps   = room;
            exp_sat = 1'b1;
        end else begin
            steps   = len;
            exp_sat = 1'b0;
        end
        exp_final = d ? ((int'(c0) + steps) % 256) : ((int'(c0) - steps + 256) % 256);
        exp_lat   = 1 + steps + (exp_sat ? 1 : 0);

        @(negedge clk);
        bus.req_valid = mask;
        bus.req_dir   = dirs;
        bus.req_len   = lens;
        bus.sat_en    = sat;
        load          = 1'b1;
        load_val      = c0;
        #1;
        check("accept_ready", bus.req_ready, 32'd1 << g);
        check("accept_busy", bus.busy, 0);

        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            load          = 1'b0;
            bus.req_valid = '0;
            #1;
            cyc++;
            check("inc_dec_excl", bus.inc & bus.dec, 0);
            check("ready_quiet", bus.req_ready, 0);
            if (bus.inc) n_inc++;
            if (bus.dec) n_dec++;
            if (bus.done) seen = 1'b1;
        end
        model_rr = (g + 1) % int'(NUM_REQ);

        check("done_seen", seen, 1);
        check("done_latency", cyc, exp_lat);
        check("sat_stop", bus.sat_stop, exp_sat);
        check("grant_id", bus.grant_id, g);
        check("final_cnt", bus.cnt, exp_final);
        check("inc_count", n_inc, d ? steps : 0);
        check("dec_count", n_dec, d ? 0 : steps);

        @(negedge clk);
        #1;
        check("done_one_cycle", bus.done, 0);
        check("idle_busy", bus.busy, 0);
    endtask

    initial begin
        int n_inc;
        bit quiet;
        logic [7:0] c0;

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_dir   = '0;
        bus.req_len   = '0;
        bus.sat_en    = 1'b0;
        load          = 1'b1;
        load_val      = 8'h00;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_inc", bus.inc, 0);
        check("rst_dec", bus.dec, 0);
        check("rst_done", bus.done, 0);
        check("rst_sat_stop", bus.sat_stop, 0);
        check("rst_grant_id", bus.grant_id, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin with all four requesting len=1: grants 0,1,2,3,0 every 3 cycles.
        @(negedge clk);
        bus.req_valid = 4'hF;
        bus.req_dir   = 4'hF;
        bus.req_len   = 16'h1111;
        load          = 1'b1;
        load_val      = 8'h40;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                @(negedge clk);
                load = 1'b0;
            end
            #1;
            check("rr_ready", bus.req_ready, (k % 3 == 0) ? (32'd1 << ((k / 3) % 4)) : 0);
        end
        @(negedge clk);
        bus.req_valid = '0;
        quiet = 1'b0;
        for (int i = 0; i < 10 && !quiet; i++) begin
            @(negedge clk);
            #1;
            if (!bus.busy) quiet = 1'b1;
        end
        check("rr_drain", quiet, 1);
        model_rr = 1;

        // Directed bursts.
        run_burst(4'b0001, 4'b0001, 16'h0005, 1'b0, 8'h10);
        run_burst(4'b0010, 4'b0010, 16'h0060, 1'b1, 8'hFD);
        run_burst(4'b0010, 4'b0010, 16'h0060, 1'b0, 8'hFD);
        run_burst(4'b0100, 4'b0000, 16'h0300, 1'b0, 8'h01);
        run_burst(4'b1000, 4'b1000, 16'h0000, 1'b1, 8'h77);
        run_burst(4'b0001, 4'b0000, 16'h000F, 1'b1, 8'h03);

        // Reset during step 3 of an 8-step burst.
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_dir   = 4'b0001;
        bus.req_len   = 16'h0008;
        bus.sat_en    = 1'b0;
        load          = 1'b1;
        load_val      = 8'h20;
        n_inc         = 0;
        for (int i = 0; i < 20 && n_inc < 3; i++) begin
            @(negedge clk);
            load          = 1'b0;
            bus.req_valid = '0;
            #1;
            if (bus.inc) n_inc++;
        end
        check("mid_step_reached", n_inc, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_inc", bus.inc, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        model_rr = 0;
        run_burst(4'hF, 4'hF, 16'h2222, 1'b0, 8'h00);

        // Randomized bursts.
        repeat (60) begin
            case ($urandom_range(0, 2))
                0:       c0 = 8'($urandom);
                1:       c0 = 8'hF0 + 8'($urandom_range(0, 15));
                default: c0 = 8'($urandom_range(0, 15));
            endcase
            run_burst(4'($urandom_range(1, 15)), 4'($urandom), 16'($urandom),
                      1'($urandom), c0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
